// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: loader FSM states, frame sync marker and
// instruction memory geometry used by the byte-stream loader.
package cpu_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LENGTH = 2'd1,
      DATA   = 2'd2,
      CHECK  = 2'd3
   } loader_state_e;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
   localparam int         MEM_BYTES_DEF = 64;

   // Running frame checksum: plain byte-wise XOR.
   function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] b);
      return acc ^ b;
   endfunction

endpackage

// File: rtl/instruction_loader.sv
// Framed byte-stream loader for the writable instruction memory: SYNC, LEN,
// LEN data bytes, XOR checksum. Emits one byte write per data byte.
module instruction_loader
   import cpu_pkg::*;
#(
   parameter int         MEM_BYTES = MEM_BYTES_DEF,
   parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
   input  logic        Clock,
   input  logic        ResetN,
   input  logic [7:0]  InByte,
   input  logic        InValid,
   output logic        InReady,
   output logic [31:0] WrAddress,
   output logic [7:0]  WrData,
   output logic        WrEnable,
   output logic        CpuHold,
   output logic        LoadDone,
   output logic        LoadError
);

   localparam int         ADDR_W  = $clog2(MEM_BYTES) + 1;
   localparam logic [8:0] MAX_LEN = 9'(MEM_BYTES);

   loader_state_e     state_r;
   logic [ADDR_W-1:0] addr_r;
   logic [ADDR_W-1:0] count_r;
   logic [7:0]        xor_r;
   logic              in_ready_r;
   logic [ADDR_W-1:0] wr_addr_r;
   logic [7:0]        wr_data_r;
   logic              wr_enable_r;
   logic              cpu_hold_r;
   logic              load_done_r;
   logic              load_error_r;

   logic              accept_s;
   logic              len_bad_s;
   logic [ADDR_W-1:0] addr_next_s;
   logic              last_s;

   assign accept_s    = InValid && in_ready_r;
   assign addr_next_s = addr_r + ADDR_W'(1);
   assign last_s      = (addr_next_s == count_r);

   // Length byte is legal only in 1..MEM_BYTES.
   always_comb begin
      len_bad_s = 1'b0;
      if (InByte == 8'd0) begin
         len_bad_s = 1'b1;
      end else if ({1'b0, InByte} > MAX_LEN) begin
         len_bad_s = 1'b1;
      end else begin
         len_bad_s = 1'b0;
      end
   end

   // Frame parser FSM with byte counter, checksum and registered outputs.
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         state_r      <= IDLE;
         addr_r       <= '0;
         count_r      <= '0;
         xor_r        <= 8'd0;
         in_ready_r   <= 1'b0;
         wr_addr_r    <= '0;
         wr_data_r    <= 8'd0;
         wr_enable_r  <= 1'b0;
         cpu_hold_r   <= 1'b0;
         load_done_r  <= 1'b0;
         load_error_r <= 1'b0;
      end else begin
         in_ready_r   <= 1'b1;
         wr_enable_r  <= 1'b0;
         load_done_r  <= 1'b0;
         load_error_r <= 1'b0;
         if (accept_s) begin
            case (state_r)
               IDLE: begin
                  if (InByte == SYNC_BYTE) begin
                     state_r    <= LENGTH;
                     cpu_hold_r <= 1'b1;
                  end else begin
                     state_r <= IDLE;
                  end
               end
               LENGTH: begin
                  if (len_bad_s) begin
                     load_error_r <= 1'b1;
                     cpu_hold_r   <= 1'b0;
                     state_r      <= IDLE;
                  end else begin
                     count_r <= ADDR_W'(InByte);
                     addr_r  <= '0;
                     xor_r   <= 8'd0;
                     state_r <= DATA;
                  end
               end
               DATA: begin
                  wr_enable_r <= 1'b1;
                  wr_addr_r   <= addr_r;
                  wr_data_r   <= InByte;
                  xor_r       <= csum_fold(xor_r, InByte);
                  addr_r      <= addr_next_s;
                  if (last_s) begin
                     state_r <= CHECK;
                  end else begin
                     state_r <= DATA;
                  end
               end
               CHECK: begin
                  cpu_hold_r <= 1'b0;
                  if (InByte == xor_r) begin
                     load_done_r <= 1'b1;
                  end else begin
                     load_error_r <= 1'b1;
                  end
                  state_r <= IDLE;
               end
               default: begin
                  cpu_hold_r <= 1'b0;
                  state_r    <= IDLE;
               end
            endcase
         end
      end
   end

   assign InReady   = in_ready_r;
   assign WrAddress = {{(32-ADDR_W){1'b0}}, wr_addr_r};
   assign WrData    = wr_data_r;
   assign WrEnable  = wr_enable_r;
   assign CpuHold   = cpu_hold_r;
   assign LoadDone  = load_done_r;
   assign LoadError = load_error_r;

endmodule
